// File: rtl/ntt_pkg.sv
// Shared constants, FSM encoding and butterfly index helpers for the NTT RAM sequencer.
package ntt_pkg;

  localparam int LOGN_DEF = 8;
  localparam int N_DEF    = 1 << LOGN_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Butterfly span at stage s: N/2 at stage 0, halving each stage.
  function automatic int bf_len(int logn, int s);
    return 1 << (logn - 1 - s);
  endfunction

  // Lower operand address: group index shifted up past the span bit, offset kept.
  function automatic int bf_a(int logn, int s, int j);
    int len;
    len = bf_len(logn, s);
    return ((j & ~(len - 1)) << 1) | (j & (len - 1));
  endfunction

  // Upper operand address sits exactly one span above the lower one.
  function automatic int bf_b(int logn, int s, int j);
    return bf_a(logn, s, j) + bf_len(logn, s);
  endfunction

  // Zeta ROM index: (1 << s) + group, group = j / span.
  function automatic int zeta_idx(int logn, int s, int j);
    return (1 << s) + (j >> (logn - 1 - s));
  endfunction

endpackage

// File: rtl/ntt_addr_dly.sv
// Fixed-depth shift register carrying {valid, a, b} from read slot to write slot.
module ntt_addr_dly #(
  parameter int W     = 17,
  parameter int DEPTH = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o
);

  logic [DEPTH-1:0][W-1:0] sr_q;

  // Shift one tap per cycle; reset flushes every in-flight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/ntt_ram_ctrl.sv
// In-place forward NTT address/write-enable sequencer for the dual-port coefficient RAM.
// Read and write slots alternate; a read's write-back lands 1+BF_LAT cycles later on a
// write slot, so the two RAM ports never see a read and a write in the same cycle.
module ntt_ram_ctrl
  import ntt_pkg::*;
#(
  parameter int BF_LAT = 4,
  parameter int LOGN   = LOGN_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [LOGN-1:0]         addr_a,
  output logic [LOGN-1:0]         addr_b,
  output logic                    we1,
  output logic                    we2,
  output logic                    bf_valid,
  output logic [LOGN-1:0]         tw_addr,
  output logic [$clog2(LOGN)-1:0] stage
);

  localparam int HALF  = (1 << LOGN) >> 1;
  localparam int JW    = LOGN - 1;
  localparam int SW    = $clog2(LOGN);
  localparam int DEPTH = 1 + BF_LAT;
  localparam int DW    = $clog2(BF_LAT + 2);
  localparam int EW    = 1 + 2 * LOGN;

  // Odd latency would put write-backs on read slots.
  if ((BF_LAT < 0) || ((BF_LAT % 2) != 0)) begin : g_bad_lat
    $error("ntt_ram_ctrl: BF_LAT must be even and non-negative");
  end

  state_e          state_q, state_d;
  logic [JW-1:0]   j_q, j_d;
  logic            phase_q, phase_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            bf_valid_q;
  logic [LOGN-1:0] tw_addr_q;

  logic            rd_slot;
  logic [LOGN-1:0] a_cur, b_cur, tw_cur;
  logic [EW-1:0]   dly_q;
  logic            dly_v;
  logic [LOGN-1:0] dly_a, dly_b;

  assign rd_slot = (state_q == RUN) && !phase_q;
  assign a_cur   = LOGN'(bf_a(LOGN, int'(stage_q), int'(j_q)));
  assign b_cur   = LOGN'(bf_b(LOGN, int'(stage_q), int'(j_q)));
  assign tw_cur  = LOGN'(zeta_idx(LOGN, int'(stage_q), int'(j_q)));

  ntt_addr_dly #(.W(EW), .DEPTH(DEPTH)) u_dly (
    .clk    (clk),
    .rst    (rst),
    .din_i  ({rd_slot, a_cur, b_cur}),
    .dout_o (dly_q)
  );

  assign dly_v = dly_q[EW-1];
  assign dly_a = dly_q[2*LOGN-1:LOGN];
  assign dly_b = dly_q[LOGN-1:0];

  // FSM state and loop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      phase_q <= 1'b0;
      stage_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      phase_q <= phase_d;
      stage_q <= stage_d;
      drain_q <= drain_d;
    end
  end

  // Butterfly-input strobe and twiddle index, one cycle behind each read slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      bf_valid_q <= 1'b0;
      tw_addr_q  <= '0;
    end else begin
      bf_valid_q <= rd_slot;
      if (rd_slot) tw_addr_q <= tw_cur;
    end
  end

  // Next-state: walk j over read slots, then drain the delay line before the next stage.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    phase_d = phase_q;
    stage_d = stage_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          j_d     = '0;
          phase_d = 1'b0;
          stage_d = '0;
        end
      end
      RUN: begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          j_d = j_q + 1'b1;
          if (j_q == JW'(HALF - 1)) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        phase_d = ~phase_q;
        drain_d = drain_q + 1'b1;
        // drain_q reaches BF_LAT on the cycle carrying the stage's last write.
        if (drain_q == DW'(BF_LAT)) begin
          if (stage_q == SW'(LOGN - 1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + 1'b1;
            j_d     = '0;
            phase_d = 1'b0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Port drive: read addresses in read slots, delayed write-back otherwise.
  always_comb begin
    addr_a = '0;
    addr_b = '0;
    we1    = 1'b0;
    we2    = 1'b0;
    if (rd_slot) begin
      addr_a = a_cur;
      addr_b = b_cur;
    end else if (dly_v) begin
      addr_a = dly_a;
      addr_b = dly_b;
      we1    = 1'b1;
      we2    = 1'b1;
    end
    busy = (state_q == RUN) || (state_q == DRAIN);
    done = (state_q == DONE);
  end

  assign bf_valid = bf_valid_q;
  assign tw_addr  = tw_addr_q;
  assign stage    = stage_q;

endmodule
